// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
//
// Purpose:
//   Sequences data-memory loads and stores issued by the MEM stage of the
//   5-stage RV32I pipeline. A single outstanding access is driven onto a
//   req/gnt/rvalid memory port. The upstream pipeline is stalled while the
//   access is in flight. Load data is lane-selected and sign/zero extended
//   before being returned on ReadDataM.
//
// Configuration:
//   DMEM_TIMEOUT_EN - when defined, an access that spends TIMEOUT_CYCLES in
//                     REQ+WAIT is aborted to ERR and flags BusErr. When
//                     undefined, REQ and WAIT wait indefinitely.
//
// Parameters:
//   TIMEOUT_CYCLES - REQ+WAIT cycle budget (timeout build only)
//   CNT_W          - timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   MemReqM, MemWriteM     MEM-stage access request, 1 = store
//   Funct3M                access size/sign (b, h, w, bu, hu)
//   ALUResultM             byte address
//   WriteDataM             right-aligned store data
//   mem_req/we/addr/wdata/wstrb   request side of the memory port
//   mem_gnt, mem_rvalid, mem_rdata response side of the memory port
//   ReadDataM              formatted load result to MEM/WB
//   StallM                 pipeline hold request
//   BusErr                 sticky error flag (misalignment or timeout)
// ---------------------------------------------------------------------------
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        BusErr
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  offset_q, offset_d;
  logic [31:0] read_data_q, read_data_d;
  logic        bus_err_q, bus_err_d;
  logic        stall;

  logic        is_byte, is_half, misaligned;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        timeout_hit;

  // Request decode: any Funct3M other than b/h/bu/hu is handled as a word.
  always_comb begin
    is_byte    = (Funct3M == 3'b000) || (Funct3M == 3'b100);
    is_half    = (Funct3M == 3'b001) || (Funct3M == 3'b101);
    misaligned = (is_half && ALUResultM[0]) ||
                 (!is_byte && !is_half && (ALUResultM[1:0] != 2'b00));
  end

  // Store lane placement: replicate the narrow datum across the word and
  // let the strobes pick the lane.
  always_comb begin
    if (is_byte) begin
      st_wstrb = 4'b0001 << ALUResultM[1:0];
      st_wdata = {4{WriteDataM[7:0]}};
    end else if (is_half) begin
      st_wstrb = 4'b0011 << ALUResultM[1:0];
      st_wdata = {2{WriteDataM[15:0]}};
    end else begin
      st_wstrb = 4'b1111;
      st_wdata = WriteDataM;
    end
  end

  // Load formatting uses the size and offset registered at request time,
  // since the pipeline inputs are not guaranteed meaningful in WAIT.
  always_comb begin
    case (offset_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

`ifdef DMEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter runs only while an access is outstanding, so it is always
  // zero on the first REQ cycle.
  always_comb begin
    cnt_d = '0;
    if ((state_q == REQ) || (state_q == WAIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // The hit fires in the last allowed cycle so that exactly TIMEOUT_CYCLES
  // cycles are spent in REQ+WAIT before ERR.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [CNT_W-1:0] unused_timeout_cfg;

  assign unused_timeout_cfg = CNT_W'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
`endif

  // Next-state and register update logic. A grant or rvalid is checked
  // before the timeout so a response in the final cycle still completes.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    funct3_d    = funct3_q;
    offset_d    = offset_q;
    read_data_d = read_data_q;
    bus_err_d   = bus_err_q;
    stall       = 1'b0;

    case (state_q)
      IDLE: begin
        if (MemReqM) begin
          stall = 1'b1;
          if (misaligned) begin
            state_d     = ERR;
            bus_err_d   = 1'b1;
            read_data_d = '0;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = MemWriteM;
            mem_addr_d  = {ALUResultM[31:2], 2'b00};
            mem_wstrb_d = MemWriteM ? st_wstrb : 4'b0000;
            mem_wdata_d = MemWriteM ? st_wdata : 32'd0;
            funct3_d    = Funct3M;
            offset_d    = ALUResultM[1:0];
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = mem_we_q ? DONE : WAIT;
        end else if (timeout_hit) begin
          mem_req_d   = 1'b0;
          state_d     = ERR;
          bus_err_d   = 1'b1;
          read_data_d = '0;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          read_data_d = ld_data;
          state_d     = DONE;
        end else if (timeout_hit) begin
          state_d     = ERR;
          bus_err_d   = 1'b1;
          read_data_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      ERR: begin
        bus_err_d   = 1'b1;
        read_data_d = '0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      funct3_q    <= '0;
      offset_q    <= '0;
      read_data_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      funct3_q    <= funct3_d;
      offset_q    <= offset_d;
      read_data_q <= read_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign ReadDataM = read_data_q;
  assign BusErr    = bus_err_q;
  assign StallM    = stall;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_ctrl
//
// Directed bench for dmem_access_ctrl. Each access pushes its expected
// memory request and its expected completion (load data, BusErr, number of
// stalled cycles) into queues; monitor processes pop and compare when the
// DUT raises mem_req or releases StallM. A simple memory responder returns
// gnt/rvalid after programmable delays.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_access_ctrl;

  localparam int TO_CYC = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemReqM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [2:0]  Funct3M = 3'b000;
  logic [31:0] ALUResultM = 32'd0;
  logic [31:0] WriteDataM = 32'd0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        BusErr;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  dmem_access_ctrl #(
    .TIMEOUT_CYCLES(TO_CYC),
    .CNT_W         (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .MemReqM   (MemReqM),
    .MemWriteM (MemWriteM),
    .Funct3M   (Funct3M),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .ReadDataM (ReadDataM),
    .StallM    (StallM),
    .BusErr    (BusErr)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          len;
  } req_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stall;
  } cpl_exp_t;

  req_exp_t req_q[$];
  cpl_exp_t cpl_q[$];
  req_exp_t cur_req;
  cpl_exp_t cur_cpl;

  int checks = 0;
  int failures = 0;
  int done_count = 0;

  int          gnt_delay = 0;
  int          rv_delay = 0;
  logic [31:0] rsp_data = 32'd0;
  logic        never_gnt = 1'b0;
  logic        spur_rvalid = 1'b0;
  int          rsp_req_cnt = 0;
  int          rsp_rv_cnt = 0;
  logic        rsp_rd_pending = 1'b0;

  logic        in_req = 1'b0;
  int          req_len = 0;
  int          cur_req_len = 0;
  int          stall_run = 0;

  function automatic void check32(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Memory responder: grants after gnt_delay REQ cycles, then returns load
  // data rvalid_delay cycles into WAIT. Optionally drives junk rvalid while
  // a request is still waiting for its grant.
  initial begin : responder
    forever begin
      @(posedge clk);
      #1;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hBAD0_BAD0;
      if (!rst) begin
        rsp_req_cnt    = 0;
        rsp_rv_cnt     = 0;
        rsp_rd_pending = 1'b0;
      end else begin
        if (rsp_rd_pending) begin
          if (rsp_rv_cnt == rv_delay) begin
            mem_rvalid     = 1'b1;
            mem_rdata      = rsp_data;
            rsp_rd_pending = 1'b0;
          end else begin
            rsp_rv_cnt++;
          end
        end
        if (mem_req) begin
          if (!never_gnt && rsp_req_cnt == gnt_delay) begin
            mem_gnt     = 1'b1;
            rsp_req_cnt = 0;
            if (!mem_we) begin
              rsp_rd_pending = 1'b1;
              rsp_rv_cnt     = 0;
            end
          end else begin
            rsp_req_cnt++;
            if (spur_rvalid) mem_rvalid = 1'b1;
          end
        end else begin
          rsp_req_cnt = 0;
        end
      end
    end
  end

  // Monitor: compares each new request against the request queue and each
  // stall release against the completion queue.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_req    = 1'b0;
        stall_run = 0;
      end else begin
        if (mem_req && !in_req) begin
          in_req  = 1'b1;
          req_len = 1;
          checks++;
          if (req_q.size() == 0) begin
            failures++;
            cur_req_len = 0;
            $display("[TB] FAIL unexpected request: got addr 0x%08h, expected no request", mem_addr);
          end else begin
            cur_req = req_q.pop_front();
            cur_req_len = cur_req.len;
            check32("req addr", mem_addr, cur_req.addr);
            check32("req we", {31'd0, mem_we}, {31'd0, cur_req.we});
            check32("req wstrb", {28'd0, mem_wstrb}, {28'd0, cur_req.wstrb});
            if (cur_req.we) check32("req wdata", mem_wdata, cur_req.wdata);
          end
        end else if (mem_req) begin
          req_len++;
        end else if (in_req) begin
          in_req = 1'b0;
          if (cur_req_len != 0) check32("req cycles", req_len, cur_req_len);
        end

        if (StallM) begin
          stall_run++;
        end else if (stall_run > 0) begin
          checks++;
          if (cpl_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected completion: got %0d stall cycles, expected none", stall_run);
          end else begin
            cur_cpl = cpl_q.pop_front();
            check32("cpl ReadDataM", ReadDataM, cur_cpl.rdata);
            check32("cpl BusErr", {31'd0, BusErr}, {31'd0, cur_cpl.err});
            check32("cpl stall cycles", stall_run, cur_cpl.stall);
          end
          stall_run = 0;
          done_count++;
        end
      end
    end
  end

  // Global time limit so a wedged run still terminates.
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected $finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic resetDut();
    MemReqM = 1'b0;
    rst     = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  task automatic waitDone(input int target, input int budget);
    int n = 0;
    while (done_count < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (done_count < target) begin
      failures++;
      $display("[TB] FAIL completion: none after %0d cycles, expected one", budget);
      req_q.delete();
      cpl_q.delete();
      resetDut();
    end
  endtask

  task automatic applyStimulus(
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input int          gd,
    input int          rd,
    input logic [31:0] rdat,
    input logic        exp_req,
    input logic [31:0] exp_addr,
    input int          exp_len,
    input logic [31:0] exp_wdata,
    input logic [3:0]  exp_wstrb,
    input logic [31:0] exp_rd,
    input logic        exp_err,
    input int          exp_stall
  );
    int target;
    @(posedge clk);
    #1;
    gnt_delay = gd;
    rv_delay  = rd;
    rsp_data  = rdat;
    if (exp_req) req_q.push_back('{exp_addr, we, exp_wdata, exp_wstrb, exp_len});
    cpl_q.push_back('{exp_rd, exp_err, exp_stall});
    target     = done_count + 1;
    MemReqM    = 1'b1;
    MemWriteM  = we;
    Funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    waitDone(target, 200);
    MemReqM = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic exp_req,
                             input logic exp_stall, input logic [31:0] exp_rd,
                             input logic exp_err);
    @(negedge clk);
    check32({tag, " mem_req"}, {31'd0, mem_req}, {31'd0, exp_req});
    check32({tag, " StallM"}, {31'd0, StallM}, {31'd0, exp_stall});
    check32({tag, " ReadDataM"}, ReadDataM, exp_rd);
    check32({tag, " BusErr"}, {31'd0, BusErr}, {31'd0, exp_err});
  endtask

  // Directed sequence; expected values are worked out by hand per vector.
  initial begin : stimulus
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("reset mem_we", {31'd0, mem_we}, 32'd0);
    check32("reset mem_addr", mem_addr, 32'd0);
    check32("reset mem_wdata", mem_wdata, 32'd0);
    check32("reset mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    checkOutput("reset", 1'b0, 1'b0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // we  f3      addr          wdata         gd rd rdata         req addr         len wdata         wstrb    rd            err stall
    applyStimulus(0, 3'b010, 32'h0000_0100, 32'd0,        0, 0, 32'hDEAD_BEEF, 1, 32'h0000_0100, 1, 32'd0,        4'b0000, 32'hDEAD_BEEF, 0, 3);
    spur_rvalid = 1'b1;
    applyStimulus(1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 4, 0, 32'd0,        1, 32'h0000_0100, 5, 32'hA5A5_A5A5, 4'b1000, 32'hDEAD_BEEF, 0, 6);
    spur_rvalid = 1'b0;
    applyStimulus(0, 3'b000, 32'h0000_0102, 32'd0,        0, 1, 32'h0080_0000, 1, 32'h0000_0100, 1, 32'd0,        4'b0000, 32'hFFFF_FF80, 0, 4);
    applyStimulus(0, 3'b100, 32'h0000_0102, 32'd0,        0, 0, 32'h0080_0000, 1, 32'h0000_0100, 1, 32'd0,        4'b0000, 32'h0000_0080, 0, 3);
    applyStimulus(0, 3'b001, 32'h0000_0106, 32'd0,        1, 0, 32'h8001_1234, 1, 32'h0000_0104, 2, 32'd0,        4'b0000, 32'hFFFF_8001, 0, 4);
    applyStimulus(0, 3'b101, 32'h0000_0104, 32'd0,        0, 0, 32'h8001_F234, 1, 32'h0000_0104, 1, 32'd0,        4'b0000, 32'h0000_F234, 0, 3);
    applyStimulus(1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 0, 0, 32'd0,        1, 32'h0000_0200, 1, 32'hABCD_ABCD, 4'b1100, 32'h0000_F234, 0, 2);
    applyStimulus(0, 3'b010, 32'h0000_0101, 32'd0,        0, 0, 32'd0,        0, 32'd0,        0, 32'd0,        4'b0000, 32'd0,         1, 1);
    applyStimulus(1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 0, 0, 32'd0,        1, 32'h0000_0300, 1, 32'hCAFE_F00D, 4'b1111, 32'd0,         1, 2);
    applyStimulus(0, 3'b011, 32'h0000_0402, 32'd0,        0, 0, 32'd0,        0, 32'd0,        0, 32'd0,        4'b0000, 32'd0,         1, 1);
    applyStimulus(0, 3'b011, 32'h0000_0400, 32'd0,        0, 0, 32'h1357_9BDF, 1, 32'h0000_0400, 1, 32'd0,        4'b0000, 32'h1357_9BDF, 1, 3);
    applyStimulus(1, 3'b000, 32'h0000_0401, 32'h1234_567E, 0, 0, 32'd0,        1, 32'h0000_0400, 1, 32'h7E7E_7E7E, 4'b0010, 32'h1357_9BDF, 1, 2);

    never_gnt = 1'b1;
`ifdef DMEM_TIMEOUT_EN
    applyStimulus(0, 3'b010, 32'h0000_0600, 32'd0,        0, 0, 32'd0,        1, 32'h0000_0600, TO_CYC, 32'd0, 4'b0000, 32'd0,       1, TO_CYC + 1);
`else
    @(posedge clk);
    #1;
    req_q.push_back('{32'h0000_0600, 1'b0, 32'd0, 4'b0000, 0});
    MemReqM    = 1'b1;
    MemWriteM  = 1'b0;
    Funct3M    = 3'b010;
    ALUResultM = 32'h0000_0600;
    repeat (120) @(posedge clk);
    checkOutput("no timeout", 1'b1, 1'b1, 32'h1357_9BDF, 1'b1);
    @(posedge clk);
    #3;
    rst     = 1'b0;
    MemReqM = 1'b0;
    checkOutput("reset in REQ", 1'b0, 1'b0, 32'd0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
`endif
    never_gnt = 1'b0;

    applyStimulus(0, 3'b001, 32'h0000_0701, 32'd0,        0, 0, 32'd0,        0, 32'd0,        0, 32'd0,        4'b0000, 32'd0,         1, 1);
    applyStimulus(0, 3'b010, 32'h0000_0900, 32'd0,        0, 0, 32'h2468_ACE0, 1, 32'h0000_0900, 1, 32'd0,        4'b0000, 32'h2468_ACE0, 1, 3);

    // Reset while the load sits in WAIT (rvalid far in the future).
    @(posedge clk);
    #1;
    gnt_delay = 0;
    rv_delay  = 40;
    rsp_data  = 32'h5555_AAAA;
    req_q.push_back('{32'h0000_0800, 1'b0, 32'd0, 4'b0000, 1});
    MemReqM    = 1'b1;
    MemWriteM  = 1'b0;
    Funct3M    = 3'b010;
    ALUResultM = 32'h0000_0800;
    repeat (3) @(posedge clk);
    checkOutput("in WAIT", 1'b0, 1'b1, 32'h2468_ACE0, 1'b1);
    #2;
    rst     = 1'b0;
    MemReqM = 1'b0;
    checkOutput("reset in WAIT", 1'b0, 1'b0, 32'd0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    checkOutput("after reset", 1'b0, 1'b0, 32'd0, 1'b0);

    applyStimulus(0, 3'b010, 32'h0000_0500, 32'd0,        0, 0, 32'h0F0F_0F0F, 1, 32'h0000_0500, 1, 32'd0,        4'b0000, 32'h0F0F_0F0F, 0, 3);

    repeat (3) @(posedge clk);
    checks++;
    if (req_q.size() != 0 || cpl_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL leftover expectations: got %0d req and %0d cpl pending, expected 0", req_q.size(), cpl_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
